// File: rtl/ego1_pkg.sv
// Shared EGO1 board constants: clock frequency, debounce default and FSM state encodings.
package ego1_pkg;

  localparam int BOARD_CLK_HZ  = 100_000_000;
  localparam int DEF_DB_CYCLES = 2_000_000;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer with async active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_debounce_pulse.sv
// Push-button debouncer: synchronized, windowed press/release with registered pulses and press counter.
// Optional release pulse output when BTN_RELEASE_PULSE_EN is defined.
//
// state        | meaning
// IDLE         | button released, level 0
// PRESS_WAIT   | btn_s high, counting toward a confirmed press
// HELD         | press confirmed, level 1
// RELEASE_WAIT | btn_s low, counting toward a confirmed release, level still 1
module btn_debounce_pulse
  import ego1_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int CNT_W     = 8
) (
  input  logic             sys_clk_in,
  input  logic             sys_rst_n,
  input  logic             btn_1,
  output logic             btn_level,
  output logic             btn_press_pulse,
`ifdef BTN_RELEASE_PULSE_EN
  output logic             btn_release_pulse,
`endif
  output logic [CNT_W-1:0] press_cnt
);

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            btn_s;
  logic [1:0]      state, state_nxt;
  logic [DB_W-1:0] cnt, cnt_nxt;
  logic            press_hit;
`ifdef BTN_RELEASE_PULSE_EN
  logic            rel_hit;
`endif

  sync_2ff u_sync (
    .clk   (sys_clk_in),
    .rst_n (sys_rst_n),
    .d     (btn_1),
    .q     (btn_s)
  );

  // Any bounce in a wait state drops back and clears the count: no partial credit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press_hit = 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
    rel_hit   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (btn_s) begin
          state_nxt = ST_PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!btn_s) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
          press_hit = 1'b1;
        end else begin
          cnt_nxt = cnt + DB_W'(1);
        end
      end
      ST_HELD: begin
        if (!btn_s) begin
          state_nxt = ST_RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (btn_s) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
`ifdef BTN_RELEASE_PULSE_EN
          rel_hit   = 1'b1;
`endif
        end else begin
          cnt_nxt = cnt + DB_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      btn_level       <= 1'b0;
      btn_press_pulse <= 1'b0;
      press_cnt       <= '0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      btn_level       <= (state_nxt == ST_HELD) || (state_nxt == ST_RELEASE_WAIT);
      btn_press_pulse <= press_hit;
      press_cnt       <= press_cnt + CNT_W'(press_hit);
    end
  end

`ifdef BTN_RELEASE_PULSE_EN
  always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) btn_release_pulse <= 1'b0;
    else            btn_release_pulse <= rel_hit;
  end
`endif

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse (DB_CYCLES=8): directed scenarios plus random bounce, checked
// every cycle against a run-length reference model of the debounce rule.
`timescale 1ns/1ps
module tb_btn_debounce_pulse;

  localparam int DB    = 8;
  localparam int CNT_W = 8;

  logic             sys_clk_in = 1'b0;
  logic             sys_rst_n  = 1'b0;
  logic             btn_1      = 1'b0;
  logic             btn_level;
  logic             btn_press_pulse;
  logic [CNT_W-1:0] press_cnt;
`ifdef BTN_RELEASE_PULSE_EN
  logic             btn_release_pulse;
`endif

  btn_debounce_pulse #(.DB_CYCLES(DB), .CNT_W(CNT_W)) dut (
    .sys_clk_in        (sys_clk_in),
    .sys_rst_n         (sys_rst_n),
    .btn_1             (btn_1),
    .btn_level         (btn_level),
    .btn_press_pulse   (btn_press_pulse),
`ifdef BTN_RELEASE_PULSE_EN
    .btn_release_pulse (btn_release_pulse),
`endif
    .press_cnt         (press_cnt)
  );

  always #5 sys_clk_in = ~sys_clk_in;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the synchronized input seen at edge n is btn_1 sampled at edge n-2.
  // Output level flips once that seen value has differed from it for DB+1 consecutive edges.
  bit m_h1, m_h2;
  bit m_level, m_press, m_rel;
  int m_run;
  int m_cnt;

  initial begin
    forever begin
      @(posedge sys_clk_in or negedge sys_rst_n);
      if (!sys_rst_n) begin
        m_h1 = 0; m_h2 = 0; m_level = 0; m_press = 0; m_rel = 0; m_run = 0; m_cnt = 0;
      end else begin
        bit seen;
        seen    = m_h2;
        m_h2    = m_h1;
        m_h1    = btn_1;
        m_press = 0;
        m_rel   = 0;
        if (seen != m_level) m_run++;
        else                 m_run = 0;
        if (m_run == DB + 1) begin
          m_run   = 0;
          m_level = !m_level;
          if (m_level) begin
            m_press = 1;
            m_cnt   = (m_cnt + 1) % (1 << CNT_W);
          end else begin
            m_rel = 1;
          end
        end
      end
    end
  end

  // Per-cycle checker, sampled 1 ns after each rising edge.
  int cyc = 0;
  int n_pulses = 0;
  int last_pulse_cyc = -1;
  int last_fall_cyc = -1;
  int last_rel_cyc = -1;
  bit prev_level = 0;

  initial begin
    forever begin
      @(posedge sys_clk_in);
      #1;
      cyc++;
      chk("level", btn_level, m_level);
      chk("press_pulse", btn_press_pulse, m_press);
      chk("press_cnt", press_cnt, m_cnt);
`ifdef BTN_RELEASE_PULSE_EN
      chk("release_pulse", btn_release_pulse, m_rel);
      if (btn_release_pulse) last_rel_cyc = cyc;
`endif
      if (btn_press_pulse) begin
        n_pulses++;
        last_pulse_cyc = cyc;
      end
      if (prev_level && !btn_level) last_fall_cyc = cyc;
      prev_level = btn_level;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk_in);
  endtask

  task automatic do_reset(input int n);
    sys_rst_n = 1'b0;
    step(n);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    int k, p0;

    // Reset with the button held
    btn_1 = 1'b1;
    step(5);
    chk("rst_level", btn_level, 0);
    chk("rst_pulse", btn_press_pulse, 0);
    chk("rst_cnt", press_cnt, 0);
    btn_1 = 1'b0;
    step(1);
    sys_rst_n = 1'b1;
    step(5);

    // Clean press: pulse 10 edges after first high sample
    p0 = n_pulses;
    btn_1 = 1'b1;
    k = cyc + 1;
    step(30);
    chk("clean_npulse", n_pulses - p0, 1);
    chk("clean_latency", last_pulse_cyc - k, DB + 2);
    chk("clean_level", btn_level, 1);
    chk("clean_cnt", press_cnt, 1);
    btn_1 = 1'b0;
    step(20);

    // Bounce from reset: never stable long enough
    do_reset(2);
    p0 = n_pulses;
    for (int r = 0; r < 5; r++) begin
      btn_1 = 1'b1; step(3);
      btn_1 = 1'b0; step(2);
    end
    step(20);
    chk("bounce_npulse", n_pulses - p0, 0);
    chk("bounce_level", btn_level, 0);
    chk("bounce_cnt", press_cnt, 0);

    // Release glitch then clean release
    btn_1 = 1'b1; step(30);
    btn_1 = 1'b0; step(4);
    btn_1 = 1'b1; step(2);
    chk("glitch_level", btn_level, 1);
    btn_1 = 1'b0;
    k = cyc + 1;
    step(20);
    chk("release_latency", last_fall_cyc - k, DB + 2);
`ifdef BTN_RELEASE_PULSE_EN
    chk("release_pulse_cyc", last_rel_cyc, last_fall_cyc);
`endif

    // Random bouncing segments
    for (int r = 0; r < 60; r++) begin
      btn_1 = 1'($urandom_range(0, 1));
      step($urandom_range(1, 14));
    end
    btn_1 = 1'b0;
    step(20);

    // Wrap: 256 clean press/release cycles from reset
    do_reset(2);
    p0 = n_pulses;
    for (int r = 0; r < 256; r++) begin
      btn_1 = 1'b1; step(DB + 6);
      btn_1 = 1'b0; step(DB + 6);
    end
    chk("wrap_npulse", n_pulses - p0, 256);
    chk("wrap_cnt", press_cnt, 0);

    // Reset in PRESS_WAIT at count 5, button still held
    btn_1 = 1'b1;
    step(DB);
    sys_rst_n = 1'b0;
    step(3);
    sys_rst_n = 1'b1;
    k = cyc + 1;
    p0 = n_pulses;
    step(30);
    chk("midrst_npulse", n_pulses - p0, 1);
    chk("midrst_latency", last_pulse_cyc - k, DB + 2);
    chk("midrst_cnt", press_cnt, 1);
    btn_1 = 1'b0;
    step(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btn_debounce_pulse.md
# btn_debounce_pulse

Conditions raw EGO1 push-button S1 (`btn_1`) into a clean, system-clock-synchronous single-cycle press pulse plus a debounced level. Sits directly upstream of the clocked R-S flip-flop stage, replacing the raw button edge with `btn_press_pulse` as its clock enable. Also keeps a wrapping press counter for LED display.

## Interface
Parameters:
- `DB_CYCLES`, 2_000_000: debounce window in clocks (20 ms at 100 MHz); legal range ≥ 2.
- `CNT_W`, 8: width of `press_cnt`.

Ports:
- `sys_clk_in`  input  1  100 MHz board clock; the block's only clock.
- `sys_rst_n`  input  1  reset, asynchronous, active-low.
- `btn_1`  input  1  raw, asynchronous, bouncing button; 1 = pressed.
- `btn_level`  output  1  debounced button state.
- `btn_press_pulse`  output  1  one-cycle pulse on each confirmed press.
- `btn_release_pulse`  output  1  one-cycle pulse on each confirmed release. Present only with the macro.
- `press_cnt`  output  CNT_W  count of confirmed presses, wraps.

## Operation
- `btn_1` passes through a 2-FF synchronizer to give `btn_s`.
- Debounce counter width is $clog2(DB_CYCLES).
- FSM has 4 states.
  - IDLE: `btn_level`=0. Goes to PRESS_WAIT when `btn_s`=1, with count cleared to 0.
  - PRESS_WAIT: count increments each clock.
    - If `btn_s`=0, return to IDLE, count cleared, no pulse.
    - If count==DB_CYCLES-1 and `btn_s`=1, go to HELD. Assert `btn_press_pulse` for one clock and increment `press_cnt`.
  - HELD: `btn_level`=1. Goes to RELEASE_WAIT when `btn_s`=0, count cleared.
  - RELEASE_WAIT: `btn_level` stays 1.
    - If `btn_s`=1, return to HELD with no pulse.
    - If count==DB_CYCLES-1 and `btn_s`=0, go to IDLE.
- `btn_level` is high in HELD and RELEASE_WAIT only.
- All outputs are registered.
- `press_cnt` wraps from 2^CNT_W-1 to 0 with no flag.
- Any bounce inside a wait state restarts the full window. There is no partial credit.

## Timing
- Reset values: all outputs 0, FSM in IDLE, synchronizer FFs 0, counter 0.
- Press latency: edge k is the first edge sampling `btn_1`=1 and the input then stays stable.
  - `btn_s` rises after edge k+1.
  - PRESS_WAIT is entered at edge k+2.
  - `btn_press_pulse` and `btn_level` rise after edge k+DB_CYCLES+2.
  - The pulse falls after the next edge.
- Release latency is symmetric: DB_CYCLES+2 edges from the first low sample to `btn_level` falling.
- `btn_press_pulse` never lasts more than 1 clock, and never fires twice without an intervening confirmed release.
- Reset mid-operation:
  - Asynchronous assertion forces reset values immediately.
  - After deassertion, a still-held button is treated as a new press and needs the full DB_CYCLES+2 window.
- `press_cnt` updates on the same edge the press pulse rises.

## Configuration
- `BTN_RELEASE_PULSE_EN` defined: `btn_release_pulse` port exists. It pulses for one clock on the RELEASE_WAIT→IDLE transition, aligned with `btn_level` falling.
- Not defined: the port is absent and the FSM is otherwise identical.

## Structure
- Shared package `ego1_pkg` holds:
  - FSM state encodings (IDLE=0, PRESS_WAIT=1, HELD=2, RELEASE_WAIT=3).
  - Default `DB_CYCLES` constant.
  - Board clock frequency constant.
- One sub-module, `sync_2ff`: a 1-bit two-flop synchronizer with async active-low reset, reused by later board stages.

## Test plan
All scenarios use `DB_CYCLES`=8.
- Reset: hold `sys_rst_n`=0 with `btn_1`=1 → `btn_level`=0, `btn_press_pulse`=0, `press_cnt`=0.
- Clean press: `btn_1` rises and holds for 30 clocks → exactly one `btn_press_pulse`, 10 edges after the first high sample. `btn_level`=1 from then on. `press_cnt` goes 0→1.
- Bounce: `btn_1` toggles high 3 clocks / low 2 clocks for 5 repetitions, then stays low → no pulse, `btn_level`=0, `press_cnt`=0.
- Release glitch then release: from HELD, drive low 4 clocks, high 2, then low 20 → `btn_level` stays 1 through the glitch and falls 10 edges after the final low. With `BTN_RELEASE_PULSE_EN`, `btn_release_pulse` is high for exactly that one clock.
- Wrap: 256 clean press/release cycles → `press_cnt` returns to 0 after the 256th pulse, and exactly 256 pulses are counted.
- Reset mid-press: assert reset in PRESS_WAIT at count 5 with `btn_1` held high, deassert 3 clocks later → no pulse before 10 edges after deassertion, then exactly one pulse. `press_cnt`=1.
